// File: rtl/button_debounce_if.sv
// Button debouncer signal bundle: raw pad in, debounced level and strobes out.
// The debouncer takes the slave modport; whatever drives the pad takes the master modport.
interface button_debounce_if;
   logic btn_in;
   logic btn_level;
   logic press_pulse;
   logic release_pulse;
   logic long_press;

   modport master (
      output btn_in,
      input  btn_level,
      input  press_pulse,
      input  release_pulse,
      input  long_press
   );

   modport slave (
      input  btn_in,
      output btn_level,
      output press_pulse,
      output release_pulse,
      output long_press
   );
endinterface

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchronizer, polarity normalisation and counter-qualified debounce FSM.
// Define BUTTON_DEBOUNCE_LONG_PRESS_EN to enable the one-shot long_press strobe.
module button_debounce #(
   parameter bit ACTIVE_LOW        = 1'b1,
   parameter int DEBOUNCE_CYCLES   = 500000,
   parameter int LONG_PRESS_CYCLES = 4000000
) (
   input  logic               clock,
   input  logic               reset,
   button_debounce_if.slave   bus
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic            IDLE_PAD = ACTIVE_LOW;

   if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1) begin : g_bad_params
      $error("button_debounce: DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sync1_q, sync2_q;
   logic               level_q, level_d;
   logic               press_q, press_d;
   logic               release_q, release_d;
   logic               sync;

   assign sync = sync2_q ^ ACTIVE_LOW;

   // Any disagreement during a WAIT state falls back to the stable state with the count discarded.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
         RELEASED: begin
            if (sync) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!sync) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
               cnt_d   = '0;
               level_d = 1'b1;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (!sync) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (sync) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = RELEASED;
               cnt_d     = '0;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = RELEASED;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q   <= IDLE_PAD;
         sync2_q   <= IDLE_PAD;
         state_q   <= RELEASED;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync1_q   <= bus.btn_in;
         sync2_q   <= sync1_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign bus.btn_level     = level_q;
   assign bus.press_pulse   = press_q;
   assign bus.release_pulse = release_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
   localparam int             LP_W    = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES);

   logic [LP_W-1:0] lp_cnt_q, lp_cnt_d;
   logic            long_q, long_d;

   // Only an accepted press restarts the hold timer; a rejected release bounce keeps counting the same press.
   always_comb begin
      lp_cnt_d = lp_cnt_q;
      long_d   = 1'b0;
      if (state_q == PRESS_WAIT && state_d == PRESSED) begin
         lp_cnt_d = '0;
      end else if (state_q == PRESSED || state_q == RELEASE_WAIT) begin
         if (state_d == RELEASED) begin
            lp_cnt_d = '0;
         end else if (lp_cnt_q != LP_LAST) begin
            lp_cnt_d = lp_cnt_q + 1'b1;
            long_d   = (lp_cnt_d == LP_LAST);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lp_cnt_q <= '0;
         long_q   <= 1'b0;
      end else begin
         lp_cnt_q <= lp_cnt_d;
         long_q   <= long_d;
      end
   end

   assign bus.long_press = long_q;
`else
   assign bus.long_press = 1'b0;
`endif

endmodule
